fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port list SHALL be, in this order:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit hold of the IF/ID register and PC.
- pc_src  input  1  redirect request from decode.
- pc_decode  input  32  redirect target from decode.
- imem_req  output  1  instruction-memory request valid.
- imem_addr  output  32  byte address of requested word.
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid this cycle.
- imem_rdata  input  32  instruction word, already byte-assembled by memory.
- if_valid  output  1  IF/ID register holds a live instruction.
- if_instr  output  32  IF/ID instruction.
- if_pc  output  32  IF/ID PC.
- if_pc_next  output  32  IF/ID PC+4.
- fetch_count  output  32  count of instructions delivered to IF/ID.

Function
REQ-003 FSM SHALL have states REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-004 REQ: imem_req=1 and imem_addr=pc_cur; imem_ready=1 -> WAIT; else stay in REQ.
REQ-005 imem_req SHALL be 0 in WAIT and HOLD; imem_addr SHALL equal pc_cur in every state.
REQ-006 WAIT, imem_rvalid=1, discard=0, stall=0: load IF/ID with if_instr=imem_rdata, if_pc=pc_cur, if_pc_next=pc_cur+4, if_valid=1; pc_cur<=pc_cur+4; fetch_count+=1; -> REQ.
REQ-007 WAIT, imem_rvalid=1, discard=0, stall=1: capture imem_rdata in a hold buffer; IF/ID unchanged; -> HOLD.
REQ-008 HOLD, stall=0: load IF/ID from the hold buffer as in REQ-006 (pc_cur advance, count increment); -> REQ.
REQ-009 HOLD, stall=1: hold buffer, pc_cur and IF/ID SHALL not change.
REQ-010 WAIT, imem_rvalid=1, discard=1: drop the data; clear discard; -> REQ; IF/ID not loaded.
REQ-011 imem_rvalid SHALL be ignored in REQ and HOLD.
REQ-012 Redirect (pc_src=1) SHALL take priority over stall and over delivery in the same cycle.
REQ-013 Redirect actions: pc_cur<=pc_decode with bits [1:0] forced to 00; if_valid<=0 (flush).
REQ-014 Redirect, remaining actions by state:
- REQ with imem_ready=1: discard<=1; -> WAIT.
- REQ with imem_ready=0: stay in REQ.
- WAIT, no rvalid: discard<=1.
- WAIT with rvalid (data dropped): -> REQ.
- HOLD: hold buffer dropped; -> REQ.
REQ-015 No delivery, no redirect: stall=1 SHALL hold IF/ID including if_valid; stall=0 SHALL set if_valid<=0 (bubble) and leave the other IF/ID fields unchanged.
REQ-016 pc_cur+4 and fetch_count SHALL wrap modulo 2^32 with no flag.
REQ-017 Best-case throughput SHALL be one instruction per 2 cycles (memory with imem_ready=1 and 1-cycle rvalid).

Reset
REQ-018 reset=1 at a clock edge SHALL set:
- pc_cur=RESET_PC, state=REQ, discard=0, hold buffer=0.
- if_valid=0, if_instr=0, if_pc=0, if_pc_next=0, fetch_count=0.
REQ-019 Reset SHALL win over every other input.
REQ-020 Reset mid-WAIT or mid-HOLD SHALL abandon the transaction; a late rvalid arrives in REQ and is ignored per REQ-011.
REQ-021 The first request (imem_req=1, imem_addr=RESET_PC) SHALL be visible in the first cycle reset is low.

Verification
REQ-022 Reset release, memory with ready=1 and 1-cycle rvalid returning addr-tagged words -> if_pc sequence 0,4,8 every 2 cycles, fetch_count 1,2,3.
REQ-023 stall=1 held 3 cycles while the word at 0x8 returns -> FSM in HOLD, IF/ID keeps 0x4; after stall drops, if_pc=0x8 next cycle with the captured word.
REQ-024 pc_src=1 with pc_decode=0x103 in WAIT -> if_valid=0 next cycle, in-flight word dropped, next imem_addr=0x100, fetch_count not incremented.
REQ-025 pc_src=1 and stall=1 together in HOLD -> buffer dropped, next imem_addr=pc_decode, IF/ID flushed.
REQ-026 imem_ready low 5 cycles -> imem_req and imem_addr=pc_cur held stable, if_valid=0 bubbles.
REQ-027 reset=1 during WAIT with rvalid arriving the next cycle -> data ignored, if_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory request, IF/ID register,
// redirect/flush handling and a stall hold buffer for words that return under stall.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_decode,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_next,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_cur;
  logic [31:0] hold_buf;
  logic        discard;
  logic        deliver;
  logic [31:0] deliver_word;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc_cur;

  // A word reaches IF/ID either straight from memory or from the hold buffer.
  always_comb begin
    deliver      = 1'b0;
    deliver_word = imem_rdata;
    if (!pc_src && !stall) begin
      if (state == S_WAIT && imem_rvalid && !discard) begin
        deliver = 1'b1;
      end else if (state == S_HOLD) begin
        deliver      = 1'b1;
        deliver_word = hold_buf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc_cur      <= RESET_PC;
      discard     <= 1'b0;
      hold_buf    <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_next  <= '0;
      fetch_count <= '0;
    end else if (pc_src) begin
      pc_cur   <= pc_decode & ~32'h3;
      if_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            discard <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            state   <= S_REQ;
          end else begin
            discard <= 1'b1;
          end
        end
        S_HOLD: begin
          hold_buf <= '0;
          state    <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end else if (deliver) begin
      if_valid    <= 1'b1;
      if_instr    <= deliver_word;
      if_pc       <= pc_cur;
      if_pc_next  <= pc_cur + 32'd4;
      pc_cur      <= pc_cur + 32'd4;
      fetch_count <= fetch_count + 32'd1;
      state       <= S_REQ;
    end else begin
      // No delivery: a stall freezes IF/ID, otherwise a bubble is inserted.
      if (!stall) if_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: ;
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
